mux_key_scanner: RTL and testbench

MUX_KEY_SCANNER -- requirements
Module: mux_key_scanner

---
 rtl/mux_key_scanner.sv | 113 +++++++++++
 tb/tb_mux_key_scanner.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mux_key_scanner.sv
// Row-multiplexed key matrix scanner for an arcade core: it steps a row pointer on
// each mux_clock edge and presents debounced, active-low key data for the selected row.
module mux_key_scanner #(
  parameter int ROWS    = 7,
  parameter int COLS    = 5,
  parameter int DEB_CYC = 40000
) (
  input  logic                 clk_sys,
  input  logic                 rst_n,
  input  logic                 enable,
  input  logic                 seed_load,
  input  logic [2:0]           seed_row,
  input  logic                 mux_clock,
  input  logic [ROWS*COLS-1:0] key_raw,
  output logic [2:0]           row_sel,
  output logic [7:0]           row_shift,
  output logic [7:0]           row_data,
  output logic                 scan_tick,
  output logic                 any_key
);

  localparam int              NK       = ROWS * COLS;
  localparam int              CW       = $clog2(DEB_CYC);
  localparam logic [CW-1:0]   CNT_LAST = CW'(DEB_CYC - 1);
  localparam logic [2:0]      LAST_ROW = 3'(ROWS - 1);

  logic          r_mux_d;
  logic          r_armed;
  logic [2:0]    r_row_sel;
  logic [7:0]    r_row_shift;
  logic          r_tick;
  logic [CW-1:0] r_cnt;
  logic [NK-1:0] r_samp;
  logic [NK-1:0] r_deb;
  logic [7:0]    r_row_data;
  logic          r_any;

  logic          w_edge;
  logic          w_advance;
  logic [2:0]    w_seed_row;
  logic [2:0]    w_next_row;
  logic          w_capture;
  logic [NK-1:0] w_agree;
  logic [NK-1:0] w_shifted;
  logic [7:0]    w_row_bits;

  // r_armed blocks a level that is already high when reset releases from counting as an edge.
  assign w_edge     = mux_clock & ~r_mux_d & r_armed;
  assign w_advance  = enable & ~seed_load & w_edge;
  assign w_seed_row = (seed_row > LAST_ROW) ? 3'd0 : seed_row;
  assign w_next_row = (r_row_sel == LAST_ROW) ? 3'd0 : r_row_sel + 3'd1;
  assign w_capture  = (r_cnt == CNT_LAST);
  assign w_agree    = ~(key_raw ^ r_samp);
  assign w_shifted  = r_deb >> (int'(r_row_sel) * COLS);

  always_comb begin
    w_row_bits             = 8'hFF;
    w_row_bits[COLS-1:0]   = ~w_shifted[COLS-1:0];
  end

  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      r_mux_d     <= 1'b0;
      r_armed     <= 1'b0;
      r_row_sel   <= 3'd0;
      r_row_shift <= 8'h01;
      r_tick      <= 1'b0;
    end else begin
      r_mux_d <= mux_clock;
      r_armed <= 1'b1;
      r_tick  <= w_advance;
      if (seed_load) begin
        r_row_sel   <= w_seed_row;
        r_row_shift <= 8'h01 << w_seed_row;
      end else if (w_advance) begin
        r_row_sel   <= w_next_row;
        r_row_shift <= 8'h01 << w_next_row;
      end
    end
  end

  // A key bit only moves when two consecutive samples agree on its new value.
  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt  <= '0;
      r_samp <= '0;
      r_deb  <= '0;
    end else if (w_capture) begin
      r_cnt  <= '0;
      r_samp <= key_raw;
      r_deb  <= (r_deb & ~w_agree) | (key_raw & w_agree);
    end else begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      r_row_data <= 8'hFF;
      r_any      <= 1'b0;
    end else begin
      r_row_data <= enable ? w_row_bits : 8'hFF;
      r_any      <= |r_deb;
    end
  end

  assign row_sel   = r_row_sel;
  assign row_shift = r_row_shift;
  assign row_data  = r_row_data;
  assign scan_tick = r_tick;
  assign any_key   = r_any;

endmodule

// File: tb/tb_mux_key_scanner.sv
// Bench for mux_key_scanner: directed scenarios plus randomized scanning, checked
// against a row/debounce reference model and a scan_tick scoreboard.
module tb_mux_key_scanner;

  localparam int ROWS = 7;
  localparam int COLS = 5;
  localparam int DEB  = 8;
  localparam int NK   = ROWS * COLS;

  logic          clk_sys   = 1'b0;
  logic          rst_n     = 1'b1;
  logic          enable    = 1'b0;
  logic          seed_load = 1'b0;
  logic [2:0]    seed_row  = 3'd0;
  logic          mux_clock = 1'b0;
  logic [NK-1:0] key_raw   = '0;
  logic [2:0]    row_sel;
  logic [7:0]    row_shift;
  logic [7:0]    row_data;
  logic          scan_tick;
  logic          any_key;

  mux_key_scanner #(.ROWS(ROWS), .COLS(COLS), .DEB_CYC(DEB)) dut (
    .clk_sys   (clk_sys),
    .rst_n     (rst_n),
    .enable    (enable),
    .seed_load (seed_load),
    .seed_row  (seed_row),
    .mux_clock (mux_clock),
    .key_raw   (key_raw),
    .row_sel   (row_sel),
    .row_shift (row_shift),
    .row_data  (row_data),
    .scan_tick (scan_tick),
    .any_key   (any_key)
  );

  // clock / reset
  always #5 clk_sys = ~clk_sys;

  int checks = 0;
  int errors = 0;

  // reference model: row pointer (updated by driver), debounce state (per clock)
  logic [2:0]    exp_q[$];
  int            m_row      = 0;
  logic          m_mux_prev = 1'b1;
  int            m_cyc;
  int            m_caps;
  logic [NK-1:0] m_s;
  logic [NK-1:0] m_d;

  always @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      m_cyc  <= 0;
      m_caps <= 0;
      m_s    <= '0;
      m_d    <= '0;
    end else begin
      m_cyc <= m_cyc + 1;
      if (m_cyc % DEB == DEB - 1) begin
        m_caps <= m_caps + 1;
        for (int k = 0; k < NK; k++)
          if (key_raw[k] == m_s[k]) m_d[k] <= key_raw[k];
        m_s <= key_raw;
      end
    end
  end

  function automatic logic [7:0] exp_row_data();
    logic [7:0] v;
    v = 8'hFF;
    for (int c = 0; c < COLS; c++)
      if (m_d[m_row * COLS + c]) v[c] = 1'b0;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // driver: apply one cycle of inputs and advance the row model
  task automatic step(input logic en, input logic sl, input logic [2:0] sr, input logic mc);
    logic rise;
    enable    = en;
    seed_load = sl;
    seed_row  = sr;
    mux_clock = mc;
    rise       = mc && !m_mux_prev;
    m_mux_prev = mc;
    if (sl) begin
      m_row = (int'(sr) < ROWS) ? int'(sr) : 0;
    end else if (en && rise) begin
      m_row = (m_row + 1) % ROWS;
      exp_q.push_back(3'(m_row));
    end
    @(posedge clk_sys);
    #1;
  endtask

  task automatic pulse(input logic en);
    step(en, 1'b0, 3'd0, 1'b1);
    step(en, 1'b0, 3'd0, 1'b0);
  endtask

  task automatic wait_caps(input int n);
    int target;
    target = m_caps + n;
    for (int i = 0; i < DEB * n + 4 && m_caps < target; i++)
      step(1'b1, 1'b0, 3'd0, 1'b0);
    if (m_caps < target) begin
      errors++;
      checks++;
      $display("FAIL capture_wait: saw %0d captures, wanted %0d", m_caps, target);
    end
  endtask

  task automatic check_settled(input string name);
    step(1'b1, 1'b0, 3'd0, 1'b0);
    step(1'b1, 1'b0, 3'd0, 1'b0);
    if (m_cyc % DEB == 0) step(1'b1, 1'b0, 3'd0, 1'b0);
    check({name, "_row_sel"},   32'(row_sel),   32'(m_row));
    check({name, "_row_shift"}, 32'(row_shift), 32'(8'(32'd1 << m_row)));
    check({name, "_row_data"},  32'(row_data),  32'(exp_row_data()));
    check({name, "_any_key"},   32'(any_key),   32'(|m_d));
  endtask

  task automatic check_reset_outputs(input string name);
    check({name, "_row_sel"},   32'(row_sel),   32'd0);
    check({name, "_row_shift"}, 32'(row_shift), 32'h01);
    check({name, "_row_data"},  32'(row_data),  32'hFF);
    check({name, "_scan_tick"}, 32'(scan_tick), 32'd0);
    check({name, "_any_key"},   32'(any_key),   32'd0);
  endtask

  // scoreboard monitor: every scan_tick must match the oldest expected row
  always @(negedge clk_sys) begin : monitor
    logic [2:0] e;
    if (rst_n === 1'b1 && scan_tick === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL scan_tick: unexpected pulse at row_sel=%0d", row_sel);
      end else begin
        e = exp_q.pop_front();
        if (row_sel !== e || row_shift !== 8'(32'd1 << e)) begin
          errors++;
          $display("FAIL advance: got row_sel=%0d row_shift=%0h expected row_sel=%0d row_shift=%0h",
                   row_sel, row_shift, e, 8'(32'd1 << e));
        end
      end
    end
  end

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    logic [63:0] rnd;
    #2 rst_n = 1'b0;
    #1 check_reset_outputs("reset");
    @(posedge clk_sys); #1;
    @(posedge clk_sys); #1;
    rst_n = 1'b1;

    // mux_clock already high when reset releases: no edge
    step(1'b1, 1'b0, 3'd0, 1'b1);
    step(1'b1, 1'b0, 3'd0, 1'b1);
    step(1'b1, 1'b0, 3'd0, 1'b0);
    check("no_edge_after_reset", 32'(row_sel), 32'd0);

    // eight back-to-back pulses, wrapping at ROWS-1
    for (int i = 0; i < 8; i++) begin
      pulse(1'b1);
      if (i == 6) check("wrap_to_zero", 32'(row_sel), 32'd0);
    end
    check("after_eight", 32'(row_sel), 32'd1);
    check("ticks_consumed", 32'(exp_q.size()), 32'd0);

    // seeding
    step(1'b1, 1'b1, 3'd5, 1'b0);
    check("seed5_row_sel", 32'(row_sel), 32'd5);
    check("seed5_row_shift", 32'(row_shift), 32'h20);
    step(1'b1, 1'b1, 3'd7, 1'b0);
    check("seed7_row_sel", 32'(row_sel), 32'd0);
    check("seed7_row_shift", 32'(row_shift), 32'h01);

    // seed_load wins over a simultaneous edge
    step(1'b1, 1'b1, 3'd3, 1'b1);
    check("seed_vs_edge", 32'(row_sel), 32'd3);
    step(1'b1, 1'b0, 3'd0, 1'b0);
    check("seed_vs_edge_hold", 32'(row_sel), 32'd3);

    // debounce on row 2, column 1
    step(1'b1, 1'b1, 3'd2, 1'b0);
    key_raw[2 * COLS + 1] = 1'b1;
    wait_caps(2);
    check("deb_before_latency", 32'(row_data), 32'hFF);
    step(1'b1, 1'b0, 3'd0, 1'b0);
    check("deb_row_data", 32'(row_data), 32'hFD);
    check("deb_any_key", 32'(any_key), 32'd1);

    // one-period release glitch leaves the debounced key pressed
    wait_caps(1);
    key_raw[2 * COLS + 1] = 1'b0;
    wait_caps(1);
    key_raw[2 * COLS + 1] = 1'b1;
    wait_caps(2);
    check_settled("glitch");
    check("glitch_row_data", 32'(row_data), 32'hFD);

    // disabled: edges ignored, row_data forced high
    for (int i = 0; i < 3; i++) pulse(1'b0);
    check("disabled_row_sel", 32'(row_sel), 32'd2);
    check("disabled_row_data", 32'(row_data), 32'hFF);
    check("disabled_tick", 32'(scan_tick), 32'd0);
    step(1'b1, 1'b0, 3'd0, 1'b0);
    pulse(1'b1);
    check("resume_row_sel", 32'(row_sel), 32'd3);

    // asynchronous reset mid-scan on row 4 with keys debounced
    step(1'b1, 1'b1, 3'd4, 1'b0);
    key_raw[4 * COLS] = 1'b1;
    wait_caps(3);
    check_settled("pre_reset");
    #2 rst_n = 1'b0;
    exp_q.delete();
    m_row      = 0;
    m_mux_prev = 1'b1;
    #1 check_reset_outputs("async_reset");
    @(posedge clk_sys); #1;
    rst_n = 1'b1;
    check_settled("post_reset");

    // randomized scanning
    for (int it = 0; it < 300; it++) begin
      case ($urandom_range(0, 5))
        0, 1: begin
          if ($urandom_range(0, 7) == 0) begin
            step(1'b1, 1'b1, 3'($urandom_range(0, 7)), 1'b1);
            step(1'b1, 1'b0, 3'd0, 1'b0);
          end else begin
            pulse(1'b1);
          end
        end
        2: step(1'b1, 1'b1, 3'($urandom_range(0, 7)), 1'b0);
        3: begin
          rnd     = {$urandom(), $urandom()};
          key_raw = rnd[NK-1:0];
          repeat ($urandom_range(0, 2 * DEB)) step(1'b1, 1'b0, 3'd0, 1'b0);
        end
        4: begin
          repeat ($urandom_range(1, 3)) pulse(1'b0);
          checks++;
          if (row_data !== 8'hFF) begin
            errors++;
            $display("FAIL rand_disabled_row_data: got %0h expected ff", row_data);
          end
        end
        default: check_settled("rand");
      endcase
      repeat ($urandom_range(0, 2)) step(1'b1, 1'b0, 3'd0, 1'b0);
    end
    check_settled("final");
    repeat (3) step(1'b1, 1'b0, 3'd0, 1'b0);
    check("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
